// File: rtl/fp_reciprocal_nr.sv
// Single-precision reciprocal 1/d by fixed-point Newton-Raphson on one shared
// 32x32 multiplier; valid/ready handshake, one operation in flight.
module fp_reciprocal_nr #(
  parameter int unsigned ITERS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        dbz,
  output logic        uflow
);

  // x0 = 48/17 - (32/17)*D, constants in Q2.30
  localparam logic [31:0] C48 = 32'((64'd48 << 30) / 64'd17);
  localparam logic [31:0] C32 = 32'((64'd32 << 30) / 64'd17);
  localparam logic [31:0] TWO = 32'h8000_0000;

  typedef enum logic [2:0] {IDLE, INIT, MUL_T, MUL_X, PACK, HOLD} state_t;

  state_t      state, state_nx;
  logic [1:0]  cnt;
  logic        sgn;
  logic [7:0]  expo;
  logic [22:0] man;
  logic [31:0] dq;     // D, Q1.31 in [0.5,1)
  logic [31:0] x;      // estimate of 1/D, Q2.30
  logic [31:0] t;      // D*x, Q2.30

  logic [31:0] ma, mb;
  logic [63:0] prod;
  logic [23:0] rnd;
  logic [31:0] pack_q;
  logic        pack_dbz, pack_uflow;
  logic        unused_bits;

  assign in_ready    = (state == IDLE);
  assign unused_bits = ^{prod[63], prod[29:0]};

  always_comb begin
    ma = dq;
    mb = C32;
    case (state)
      MUL_T: mb = x;
      MUL_X: begin
        ma = x;
        mb = TWO - t;
      end
      default: ;
    endcase
    prod = 64'(ma) * 64'(mb);
  end

  // Round on the 7 guard bits below the 23-bit fraction; carry-out bumps the exponent
  always_comb begin
    pack_q     = '0;
    pack_dbz   = 1'b0;
    pack_uflow = 1'b0;
    rnd        = {1'b0, x[29:7]} + {23'd0, x[6]};
    if (expo == 8'hFF) begin
      pack_q = (man != '0) ? 32'h7FC0_0000 : {sgn, 31'h0};
    end else if (expo == 8'h00) begin
      pack_q   = {sgn, 8'hFF, 23'h0};
      pack_dbz = 1'b1;
    end else if (man == '0) begin
      if (expo == 8'd254) begin
        pack_q     = {sgn, 31'h0};
        pack_uflow = 1'b1;
      end else begin
        pack_q = {sgn, 8'd254 - expo, 23'h0};
      end
    end else if (expo >= 8'd253) begin
      pack_q     = {sgn, 31'h0};
      pack_uflow = 1'b1;
    end else begin
      pack_q = {sgn, 8'd253 - expo + {7'd0, rnd[23]}, rnd[22:0]};
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = INIT;
      INIT:    state_nx = MUL_T;
      MUL_T:   state_nx = MUL_X;
      MUL_X:   state_nx = (cnt == 2'(ITERS - 1)) ? PACK : MUL_T;
      PACK:    state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sgn       <= 1'b0;
      expo      <= '0;
      man       <= '0;
      dq        <= '0;
      x         <= '0;
      t         <= '0;
      q         <= '0;
      out_valid <= 1'b0;
      dbz       <= 1'b0;
      uflow     <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          sgn  <= d[31];
          expo <= d[30:23];
          man  <= d[22:0];
          dq   <= {2'b01, d[22:0], 7'd0};
          cnt  <= '0;
        end
        INIT:  x <= C48 - prod[62:31];
        MUL_T: t <= prod[62:31];
        MUL_X: begin
          x   <= prod[61:30];
          cnt <= cnt + 2'd1;
        end
        PACK: begin
          q         <= pack_q;
          dbz       <= pack_dbz;
          uflow     <= pack_uflow;
          out_valid <= 1'b1;
        end
        HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_reciprocal_nr.sv
// Randomized and directed bench for fp_reciprocal_nr against an exact-division
// reference model of the binary32 reciprocal.
module tb_fp_reciprocal_nr;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] d = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, dbz, uflow;
  logic [31:0] q;

  fp_reciprocal_nr #(.ITERS(3)) dut (
    .clk(clk), .rst(rst), .d(d), .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .out_valid(out_valid), .out_ready(out_ready), .dbz(dbz), .uflow(uflow)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic [31:0] q;
    logic        dbz;
    logic        uflow;
    bit          tol;
    int unsigned acc;
  } exp_t;
  exp_t expq[$];

  // Reference: correctly rounded 2^47/M mantissa by integer division
  task automatic model(input logic [31:0] dv, output logic [31:0] qm,
                       output logic dz, output logic uf, output bit tol);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [63:0] mm, r;
    logic [7:0]  ex;
    s = dv[31]; e = dv[30:23]; m = dv[22:0];
    qm = '0; dz = 1'b0; uf = 1'b0; tol = 1'b0;
    if (e == 8'd255) qm = (m != 0) ? 32'h7FC0_0000 : {s, 31'h0};
    else if (e == 8'd0) begin qm = {s, 8'hFF, 23'h0}; dz = 1'b1; end
    else if (m == 0) begin
      if (e == 8'd254) begin qm = {s, 31'h0}; uf = 1'b1; end
      else qm = {s, 8'(254 - int'(e)), 23'h0};
    end else if (e >= 8'd253) begin qm = {s, 31'h0}; uf = 1'b1; end
    else begin
      mm = {40'd0, 1'b1, m};
      r  = (((64'd1 << 48) / mm) + 64'd1) >> 1;
      ex = 8'(253 - int'(e));
      if (r >= (64'd1 << 24)) begin r = 64'd1 << 23; ex = ex + 8'd1; end
      qm  = {s, ex, r[22:0]};
      tol = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic chk_ulp(input string nm, input logic [31:0] act, input logic [31:0] req);
    logic [31:0] dl;
    vectors++;
    dl = (act[30:0] > req[30:0]) ? 32'(act[30:0] - req[30:0]) : 32'(req[30:0] - act[30:0]);
    if ($isunknown(act) || act[31] != req[31] || dl > 1) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (+-1 ulp)", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout/unexpected event, required handshake", nm);
  endtask

  // Output compare: latency, handshake exclusivity and result per transfer
  bit ov_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) ov_prev = 1'b0;
    else begin
      chk("ready_valid_excl", 32'(in_ready & out_valid), 32'd0);
      if (out_valid && !ov_prev) begin
        if (expq.size() == 0) fail("spurious_out_valid");
        else chk("latency", cyc - expq[0].acc, 32'd8);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) fail("spurious_result");
        else begin
          exp_t e;
          e = expq.pop_front();
          if (e.tol) chk_ulp("q", q, e.q);
          else       chk("q_exact", q, e.q);
          chk("dbz", 32'(dbz), 32'(e.dbz));
          chk("uflow", 32'(uflow), 32'(e.uflow));
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic send(input logic [31:0] dv, output int unsigned acc);
    int unsigned n;
    exp_t e;
    n = 0;
    d = dv;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      fail("accept_timeout");
      in_valid = 1'b0;
      acc = 0;
      return;
    end
    acc = cyc + 1;
    e.d = dv;
    model(dv, e.q, e.dbz, e.uflow, e.tol);
    e.acc = acc;
    expq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    d = $urandom;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (expq.size() != 0 && n < 100) begin @(posedge clk); n++; end
    if (expq.size() != 0) fail("drain_timeout");
    @(posedge clk); #1;
  endtask

  localparam int NPIN = 8;
  logic [31:0] pin_d [NPIN] = '{32'h4080_0000, 32'h4040_0000, 32'hC254_0000, 32'h0000_0000,
                                32'h8000_0001, 32'h7F80_0000, 32'h7FA0_0000, 32'h7F00_0000};
  logic [31:0] pin_q [NPIN] = '{32'h3E80_0000, 32'h3EAA_AAAB, 32'hBC9A_90E8, 32'h7F80_0000,
                                32'hFF80_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h0000_0000};
  logic        pin_dz[NPIN] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        pin_uf[NPIN] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int unsigned acc, last_acc, n;
    logic [31:0] qm, dv;
    logic dz, uf;
    bit tol;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_dbz_uflow", 32'({dbz, uflow}), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < NPIN; i++) begin
      model(pin_d[i], qm, dz, uf, tol);
      chk("model_q", qm, pin_q[i]);
      chk("model_flags", 32'({dz, uf}), 32'({pin_dz[i], pin_uf[i]}));
    end

    for (int i = 0; i < NPIN; i++) send(pin_d[i], acc);
    drain();

    // Reset in the middle of an iteration discards the operation
    send(32'h3FC0_0000, acc);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 expq.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_q", q, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    send(32'h40A0_0000, acc);
    drain();

    // Backpressure: result held, second operand ignored
    out_ready = 1'b0;
    dv = 32'h4040_0000;
    model(dv, qm, dz, uf, tol);
    send(dv, acc);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    if (!out_valid) fail("bp_out_valid_timeout");
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin in_valid = 1'b1; d = 32'h4100_0000; end
      if (i == 6) in_valid = 1'b0;
      @(posedge clk); #1;
      chk_ulp("bp_q_stable", q, qm);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    drain();

    // Random normal operands, back-to-back
    last_acc = 0;
    for (int i = 0; i < 1000; i++) begin
      dv = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom_range(1, 32'h7F_FFFF))};
      send(dv, acc);
      if (i > 0) chk("throughput", acc - last_acc, 32'd10);
      last_acc = acc;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
